// File: rtl/clock_gate_pkg.sv
// Shared types and defaults for the per-domain clock-gating controller.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// Contents: per-domain FSM state type and default timing parameters.
package clock_gate_pkg;

  // Two bits per domain; 2'b11 is unused and treated as ON so clocks keep running.
  typedef enum logic [1:0] {
    CG_ON     = 2'b00,
    CG_OFF    = 2'b01,
    CG_WAKING = 2'b10
  } cg_state_t;

  localparam int CG_IDLE_CYC_DEF = 16;
  localparam int CG_WAKE_CYC_DEF = 2;

endpackage

// File: rtl/cg_domain_fsm.sv
// One domain's gating FSM: idle countdown to OFF, timed wake through WAKING to ON.
// Latency: clk_en falls on the IDLE_CYC-th idle edge; wake to ON takes WAKE_CYC+1 edges.
// Backpressure: none; wake_req is a level held by the requester until wake_ack.
//
// Ports:
//   clk_in   - free-running clock
//   rst_n    - synchronous active-low reset (domain returns to ON)
//   active   - busy | wake_req | force_on for this domain
//   wake_req - raw wake request, only used to qualify wake_ack
//   clk_en   - registered enable for the clock gating cell
//   wake_ack - domain is ON and the request is still present
//   dom_on   - domain is in the ON state
module cg_domain_fsm
  import clock_gate_pkg::*;
#(
  parameter int IDLE_CYC = CG_IDLE_CYC_DEF,
  parameter int WAKE_CYC = CG_WAKE_CYC_DEF
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic active,
  input  logic wake_req,
  output logic clk_en,
  output logic wake_ack,
  output logic dom_on
);

  localparam int CNT_W = $clog2(IDLE_CYC + 1);
  localparam int WK_W  = $clog2(WAKE_CYC + 1);

  cg_state_t        state_q, state_d;
  logic [CNT_W-1:0] idle_q,  idle_d;
  logic [WK_W-1:0]  wk_q,    wk_d;
  logic             clk_en_q;

  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    wk_d    = wk_q;
    case (state_q)
      CG_OFF: begin
        if (active) begin
          state_d = CG_WAKING;
          wk_d    = WK_W'(WAKE_CYC);
        end
      end
      CG_WAKING: begin
        // Inputs are ignored here: the stabilisation delay always runs to completion.
        if (wk_q <= WK_W'(1)) begin
          state_d = CG_ON;
          idle_d  = CNT_W'(IDLE_CYC);
          wk_d    = '0;
        end else begin
          wk_d = wk_q - WK_W'(1);
        end
      end
      default: begin
        // CG_ON and the unused encoding both behave as ON.
        state_d = CG_ON;
        if (active) begin
          idle_d = CNT_W'(IDLE_CYC);
        end else if (idle_q <= CNT_W'(1)) begin
          state_d = CG_OFF;
          idle_d  = CNT_W'(IDLE_CYC);
        end else begin
          idle_d = idle_q - CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q  <= CG_ON;
      idle_q   <= CNT_W'(IDLE_CYC);
      wk_q     <= '0;
      clk_en_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      idle_q   <= idle_d;
      wk_q     <= wk_d;
      // Enable is registered from the next state so the gating cell never sees
      // a combinational path from the activity inputs.
      clk_en_q <= (state_d != CG_OFF);
    end
  end

  assign clk_en   = clk_en_q;
  assign dom_on   = (state_q != CG_OFF) && (state_q != CG_WAKING);
  assign wake_ack = dom_on & wake_req;

endmodule

// File: rtl/clock_gate_ctrl.sv
// Per-domain clock-enable controller driving N_DOM clock gating cells.
// Latency: gating after IDLE_CYC idle edges; wake ack WAKE_CYC+1 edges after request from OFF.
// Backpressure: none; wake_req is held until wake_ack, force_on overrides gating globally.
//
// Ports:
//   clk_in   - free-running (ungated) clock
//   rst_n    - synchronous active-low reset, all domains to ON
//   force_on - keep/bring every domain up
//   busy     - per-domain activity
//   wake_req - per-domain wake request (level)
//   clk_en   - registered per-domain gate enable
//   wake_ack - per-domain wake acknowledge
//   dom_on   - per-domain ON status
module clock_gate_ctrl
  import clock_gate_pkg::*;
#(
  parameter int N_DOM    = 4,
  parameter int IDLE_CYC = CG_IDLE_CYC_DEF,
  parameter int WAKE_CYC = CG_WAKE_CYC_DEF
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             force_on,
  input  logic [N_DOM-1:0] busy,
  input  logic [N_DOM-1:0] wake_req,
  output logic [N_DOM-1:0] clk_en,
  output logic [N_DOM-1:0] wake_ack,
  output logic [N_DOM-1:0] dom_on
);

  for (genvar i = 0; i < N_DOM; i++) begin : g_dom
    logic active;
    assign active = busy[i] | wake_req[i] | force_on;

    cg_domain_fsm #(
      .IDLE_CYC (IDLE_CYC),
      .WAKE_CYC (WAKE_CYC)
    ) u_fsm (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .active   (active),
      .wake_req (wake_req[i]),
      .clk_en   (clk_en[i]),
      .wake_ack (wake_ack[i]),
      .dom_on   (dom_on[i])
    );
  end

endmodule

// File: doc/clock_gate_ctrl.md
Name: clock_gate_ctrl

Overview:
- Per-domain clock-enable controller that drives the clk_en input of N clock_g gating cells.
- Tracks activity in each domain and drops its enable after IDLE_CYC consecutive idle cycles.
- Wakes a gated domain on request and acknowledges only after a fixed clock-stabilisation delay.
- Sits in the always-on clock domain, next to the gating cells, between the core's activity signals and the gated logic.

Parameters:
- N_DOM, 4: number of gated domains (1..16).
- IDLE_CYC, 16: consecutive idle cycles before gating (>=1).
- WAKE_CYC, 2: cycles spent in WAKING before ack (>=1).
- CNT_W, $clog2(IDLE_CYC+1): idle counter width (derived, do not override).
- WK_W, $clog2(WAKE_CYC+1): wake counter width (derived).

Ports:
- clk_in  input  1  free-running (ungated) clock.
- rst_n  input  1  reset; synchronous, active-low.
- force_on  input  1  global override; keeps every domain enabled.
- busy  input  N_DOM  per-domain activity; 1 = domain has work in flight.
- wake_req  input  N_DOM  per-domain wake request; level, held until wake_ack.
- clk_en  output  N_DOM  registered enable to each clock_g cell.
- wake_ack  output  N_DOM  domain is running and stable; valid only while wake_req is high.
- dom_on  output  N_DOM  status, 1 when the domain is in the ON state.

Behaviour:
- Reset: on the clk_in edge with rst_n=0, every domain goes to ON. Resulting values: clk_en=all 1, dom_on=all 1, wake_ack=0, idle_cnt=IDLE_CYC, wake_cnt=0. Clocks run out of reset. Reset mid-WAKING or mid-countdown aborts to ON immediately.
- Domains are fully independent: identical per-domain FSM, no cross-domain interaction except force_on.
- Define active[i] = busy[i] | wake_req[i] | force_on.
- State ON:
  - clk_en=1, dom_on=1.
  - If active, reload idle_cnt=IDLE_CYC.
  - Otherwise decrement idle_cnt. When idle_cnt==1 and the domain is idle, go to OFF.
  - Result: clk_en falls on the edge ending the IDLE_CYC-th consecutive idle cycle.
- State OFF:
  - clk_en=0, dom_on=0.
  - If active, go to WAKING and load wake_cnt=WAKE_CYC; clk_en=1 from the next edge.
- State WAKING:
  - clk_en=1, dom_on=0.
  - wake_cnt decrements each cycle; at wake_cnt==1 go to ON and reload idle_cnt=IDLE_CYC.
  - busy and wake_req are ignored here. Dropping wake_req still completes to ON, after which the idle countdown applies.
- wake_ack[i] = (state==ON) & wake_req[i]. This comes from the state register, so it is glitch-free.
- Wake latency from OFF: wake_req sampled at edge t; clk_en=1 after t; ON (and wake_ack) after edge t+WAKE_CYC. Total WAKE_CYC+1 edges.
- If the domain is already ON, wake_ack asserts in the same cycle as wake_req.
- clk_en is a flop output only; no combinational path from inputs to clk_en (required for clean latch-based gating).
- Simultaneous wake_req and idle_cnt==1 in ON: active wins, counter reloads, no OFF transition.
- force_on=1:
  - ON domains hold.
  - OFF domains wake through WAKING; WAKING is never skipped.
  - On release of force_on, the idle countdown starts from IDLE_CYC.
- State encoding: 2 bits per domain. The unused encoding decodes to ON (fail-safe clocks running).

Decomposition:
- Package clock_gate_pkg holds:
  - typedef enum logic [1:0] cg_state_t {CG_ON, CG_OFF, CG_WAKING}
  - localparam defaults for IDLE_CYC / WAKE_CYC.
- Sub-module cg_domain_fsm: one domain's FSM, idle counter and wake counter. Ports: clk_in, rst_n, active, wake_req, clk_en, wake_ack, dom_on.
- The top instantiates N_DOM copies in a generate loop and fans out force_on.

Test Plan:
- Reset with busy=0 for 20 cycles (IDLE_CYC=16) -> clk_en=1 for 16 cycles after reset release, then 0 from cycle 17; dom_on follows.
- Domain 2 OFF, pulse wake_req[2] at edge t and hold -> clk_en[2]=1 after t, wake_ack[2]=1 after edge t+2 (WAKE_CYC=2); other domains unchanged.
- busy[0] toggles 1 for 1 cycle every 10 cycles -> clk_en[0] never drops. Stop the toggling -> drops exactly 16 cycles after the last busy.
- force_on=1 with all domains OFF -> all clk_en=1 next edge, all dom_on=1 after 2 more edges. force_on=0 with busy=0 -> all gate 16 cycles later.
- rst_n=0 asserted while domain 1 is in WAKING with wake_cnt=1 -> next edge domain 1 is ON, clk_en=1, wake_ack=0; no extra WAKING cycles.
- wake_req[3] dropped mid-WAKING -> domain reaches ON, wake_ack[3] stays 0, gates again after 16 idle cycles.
